// File: rtl/component_phase_sequencer.sv
// Start-triggered phase sequencer: per slice, times the DC/AC VLC reset, enable and flush windows.
// Optional row-serial DCT mode (block span B = 8*N) is enabled by defining COMPONENT_PHASE_ROWMODE_EN.
module component_phase_sequencer #(
    parameter int CNT_W       = 32,
    parameter int BLK_W       = 16,
    parameter int DCT_TIME    = 10,
    parameter int DC_VLC_TIME = 44,
    parameter int WR_OFFSET   = -12,
    parameter int AC_COEFS    = 63
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [BLK_W-1:0] block_num,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sequence_counter,
    output logic [CNT_W-1:0] wr_counter,
    output logic             dc_vlc_reset,
    output logic             dc_vlc_output_enable,
    output logic [CNT_W-1:0] dc_vlc_counter,
    output logic             ac_vlc_reset,
    output logic             ac_vlc_output_enable,
    output logic             ac_vlc_output_flush,
    output logic [CNT_W-1:0] ac_vlc_counter
);

    localparam logic [CNT_W-1:0] T_C   = CNT_W'(DCT_TIME);
    localparam logic [CNT_W-1:0] D_C   = CNT_W'(DC_VLC_TIME);
    localparam logic [CNT_W-1:0] AC_C  = CNT_W'(AC_COEFS);
    localparam logic [CNT_W-1:0] OFF_C = CNT_W'(WR_OFFSET);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] seq_q, seq_d;
    logic [CNT_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] dc_rst_lo_q, dc_rst_lo_d;
    logic [CNT_W-1:0] dc_rst_hi_q, dc_rst_hi_d;
    logic [CNT_W-1:0] dc_oe_lo_q, dc_oe_lo_d;
    logic [CNT_W-1:0] dc_oe_hi_q, dc_oe_hi_d;
    logic [CNT_W-1:0] ac_rst_lo_q, ac_rst_lo_d;
    logic [CNT_W-1:0] ac_oe_lo_q, ac_oe_lo_d;
    logic [CNT_W-1:0] flush_at_q, flush_at_d;
    logic [CNT_W-1:0] end_at_q, end_at_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dc_rst_q, dc_rst_d;
    logic             dc_oe_q, dc_oe_d;
    logic             ac_rst_q, ac_rst_d;
    logic             ac_oe_q, ac_oe_d;
    logic             ac_flush_q, ac_flush_d;

    logic [CNT_W-1:0] n_ext, b_ext, a_ext, ac_tail;
    logic             active;

    always_comb begin
        n_ext = {{(CNT_W-BLK_W){1'b0}}, block_num};
`ifdef COMPONENT_PHASE_ROWMODE_EN
        b_ext = n_ext << 3;
`else
        b_ext = n_ext;
`endif
        a_ext   = T_C + b_ext + D_C;
        ac_tail = a_ext + AC_C * n_ext;

        state_d     = state_q;
        seq_d       = seq_q;
        wr_d        = wr_q;
        dc_rst_lo_d = dc_rst_lo_q;
        dc_rst_hi_d = dc_rst_hi_q;
        dc_oe_lo_d  = dc_oe_lo_q;
        dc_oe_hi_d  = dc_oe_hi_q;
        ac_rst_lo_d = ac_rst_lo_q;
        ac_oe_lo_d  = ac_oe_lo_q;
        flush_at_d  = flush_at_q;
        end_at_d    = end_at_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        // Windows are compares against the current count, registered so they appear one cycle later.
        active     = (state_q == RUN) && !abort;
        dc_rst_d   = active && (seq_q >= dc_rst_lo_q) && (seq_q < dc_rst_hi_q);
        dc_oe_d    = active && (seq_q >= dc_oe_lo_q) && (seq_q < dc_oe_hi_q);
        ac_rst_d   = active && (seq_q >= ac_rst_lo_q) && (seq_q < end_at_q);
        ac_oe_d    = active && (seq_q >= ac_oe_lo_q) && (seq_q < flush_at_q);
        ac_flush_d = active && (seq_q == flush_at_q);

        case (state_q)
            IDLE: begin
                if (start && (block_num != '0)) begin
                    state_d     = RUN;
                    busy_d      = 1'b1;
                    seq_d       = '0;
                    wr_d        = OFF_C;
                    dc_rst_lo_d = T_C + b_ext + 1'b1;
                    dc_rst_hi_d = T_C + (b_ext << 1) + CNT_W'(8);
                    dc_oe_lo_d  = T_C + b_ext + CNT_W'(7);
                    // B+N equals 2B in normal mode and 9N in row mode, so one formula covers both.
                    dc_oe_hi_d  = T_C + b_ext + n_ext + CNT_W'(7);
                    ac_rst_lo_d = a_ext + 1'b1;
                    ac_oe_lo_d  = a_ext + CNT_W'(6);
                    flush_at_d  = ac_tail + CNT_W'(6);
                    end_at_d    = ac_tail + CNT_W'(8);
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (seq_q == end_at_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    seq_d  = seq_q + 1'b1;
                    wr_d   = seq_d + OFF_C;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            wr_q        <= '0;
            dc_rst_lo_q <= '0;
            dc_rst_hi_q <= '0;
            dc_oe_lo_q  <= '0;
            dc_oe_hi_q  <= '0;
            ac_rst_lo_q <= '0;
            ac_oe_lo_q  <= '0;
            flush_at_q  <= '0;
            end_at_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dc_rst_q    <= 1'b0;
            dc_oe_q     <= 1'b0;
            ac_rst_q    <= 1'b0;
            ac_oe_q     <= 1'b0;
            ac_flush_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            wr_q        <= wr_d;
            dc_rst_lo_q <= dc_rst_lo_d;
            dc_rst_hi_q <= dc_rst_hi_d;
            dc_oe_lo_q  <= dc_oe_lo_d;
            dc_oe_hi_q  <= dc_oe_hi_d;
            ac_rst_lo_q <= ac_rst_lo_d;
            ac_oe_lo_q  <= ac_oe_lo_d;
            flush_at_q  <= flush_at_d;
            end_at_q    <= end_at_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dc_rst_q    <= dc_rst_d;
            dc_oe_q     <= dc_oe_d;
            ac_rst_q    <= ac_rst_d;
            ac_oe_q     <= ac_oe_d;
            ac_flush_q  <= ac_flush_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign sequence_counter     = seq_q;
    assign wr_counter           = wr_q;
    assign dc_vlc_reset         = dc_rst_q;
    assign dc_vlc_output_enable = dc_oe_q;
    assign ac_vlc_reset         = ac_rst_q;
    assign ac_vlc_output_enable = ac_oe_q;
    assign ac_vlc_output_flush  = ac_flush_q;
    // Stage-local counters reuse the registered window starts as their bases.
    assign dc_vlc_counter       = seq_q - dc_rst_lo_q;
    assign ac_vlc_counter       = seq_q - ac_rst_lo_q;

endmodule

// File: doc/component_phase_sequencer.md
Name: component_phase_sequencer

Overview:
- Start-triggered, parametrised successor to the free-running component sequencer.
- Per slice, latches a block count, runs a cycle counter and generates registered reset, enable and flush windows for the DC VLC and AC VLC stages.
- Also provides a write-side counter for the array-to-memory stage and a start/busy/done handshake.
- Sits between the slice controller and the DCT/DC-VLC/AC-VLC pipeline of each colour component.

Parameters:
- CNT_W, 32: width of all counters.
- BLK_W, 16: width of block_num. Requires CNT_W >= BLK_W+8.
- DCT_TIME, 10: DCT pipeline latency in cycles.
- DC_VLC_TIME, 44: DC VLC stage budget in cycles.
- WR_OFFSET, -12: signed offset applied to produce wr_counter.
- AC_COEFS, 63: AC coefficients per block.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a slice
- abort  in  1  synchronous abort of a running slice
- block_num  in  BLK_W  blocks in the slice; sampled on accepted start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of slice
- sequence_counter  out  CNT_W  run counter
- wr_counter  out  CNT_W  registered: sequence_counter + WR_OFFSET (two's-complement wrap)
- dc_vlc_reset  out  1  DC VLC active-window (reset released)
- dc_vlc_output_enable  out  1  DC VLC output window
- dc_vlc_counter  out  CNT_W  combinational: sequence_counter - (B+DCT_TIME+1)
- ac_vlc_reset  out  1  AC VLC active-window
- ac_vlc_output_enable  out  1  AC VLC output window
- ac_vlc_output_flush  out  1  one-cycle flush pulse
- ac_vlc_counter  out  CNT_W  combinational: sequence_counter - (B+DCT_TIME+DC_VLC_TIME+1)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, latched N = 0.
- Notation: N = latched block_num; B = block span (= N; see Optional Feature); T = DCT_TIME; D = DC_VLC_TIME; A = T+B+D.
- Derived thresholds are computed into registers on the accepted-start cycle. All arithmetic is unsigned CNT_W with no intermediate overflow.
- FSM:
  - IDLE: start=1 and block_num!=0 → latch N, clear sequence_counter → RUN. start with block_num==0 is ignored; busy stays 0.
  - RUN: sequence_counter increments by 1 every cycle. When sequence_counter == END (END = A + AC_COEFS*N + 8) → DONE.
  - DONE: done=1 for exactly one cycle, all windows 0 → IDLE.
- Window notation: "[X,Y)" means the output is 1 in the cycle after sequence_counter==X, through the cycle after sequence_counter==Y-1. Every window output is a registered compare.
  - dc_vlc_reset: [T+B+1, T+2B+8)
  - dc_vlc_output_enable: [T+B+7, T+2B+7)
  - ac_vlc_reset: [A+1, A+AC_COEFS*N+8)
  - ac_vlc_output_enable: [A+6, A+AC_COEFS*N+6)
  - ac_vlc_output_flush: a single cycle, after sequence_counter == A+AC_COEFS*N+6
- wr_counter updates every cycle in RUN and holds in IDLE.
- start while busy: ignored; latched N is unchanged.
- abort while busy: on the next edge, FSM → IDLE, all windows and busy → 0, done not pulsed, counters hold. abort in IDLE: no effect.
- abort and start in the same cycle in IDLE: start is accepted.
- reset mid-run: everything returns to reset values on the next edge.

Optional Feature:
- Macro: COMPONENT_PHASE_ROWMODE_EN.
- Defined: row-serial DCT mode. B = 8*N in every threshold and in dc_vlc_counter/ac_vlc_counter. The dc_vlc_output_enable window becomes [T+B+7, T+B+N+7).
- Undefined: B = N as above.

Test Plan:
- N=1, defaults, macro off → dc_vlc_reset high 8 cycles (counts 12..19); dc_vlc_output_enable 1 cycle (count 18); ac_vlc_reset 70 cycles (56..125); ac_vlc_output_enable 63 cycles (61..123); flush after count 124; done after count 126, then busy=0.
- N=4 → dc_vlc_output_enable counts 21..24; ac_vlc_output_enable counts 64..315 (252 cycles); dc_vlc_counter==0 at count 15; wr_counter == sequence_counter-12 (registered).
- start with block_num=0 → busy stays 0, no done; start during RUN with N=7 → timing stays that of the original N.
- abort at count 70 with N=2 → next cycle all windows 0, busy 0, no done; a new start then runs cleanly.
- reset asserted at count 40 → all outputs 0 next cycle; reset deasserted, start N=1 → first case repeats exactly.
- Macro on, N=1 → B=8: dc_vlc_reset counts 19..33; dc_vlc_output_enable counts 25; ac_vlc_output_enable counts 68..130.
